fa_array_reg: RTL and testbench

Registered, parameterizable array of 1-bit full adders (3:2 compressor) for the partial-product reduction tree of the MBE radix-4 multiplier. Each bit position adds `a`, `b` and `cin` and produces `sum` and `carry`. A build-time mode selects independent carry-save bits or a ripple chain. Outputs are captured in one register stage with a valid flag, so the block can be cascaded in a pipelined reduction tree.

---
 rtl/fa_array_reg_pkg.sv | 10 +
 rtl/fa_array_reg_full_adder.sv | 13 +
 rtl/fa_array_reg.sv | 73 +++++++
 tb/tb_fa_array_reg.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fa_array_reg_pkg.sv
// Shared constants for the MBE radix-4 multiplier reduction tree.
// Holds the default adder-array width and the carry-save / ripple mode selectors.
package fa_array_reg_pkg;

  localparam int unsigned FaDefaultWidth  = 1;

  localparam int unsigned FaModeCarrySave = 0;
  localparam int unsigned FaModeRipple    = 1;

endpackage

// File: rtl/fa_array_reg_full_adder.sv
// Purely combinational 1-bit full adder cell (3:2 compressor).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fa_array_reg.sv
// Registered array of full adders, either independent carry-save bits or a ripple chain,
// followed by one output register stage with a valid flag.
module fa_array_reg
  import fa_array_reg_pkg::*;
#(
  parameter int unsigned WIDTH  = FaDefaultWidth,
  parameter int unsigned RIPPLE = FaModeCarrySave
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] cin,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid
);

  logic [WIDTH-1:0] cell_sum;
  logic [WIDTH-1:0] cell_carry;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic ci;
    logic co;

    // Per-bit carry nets keep the ripple chain free of self-referencing vectors.
    if ((RIPPLE == FaModeRipple) && (i > 0)) begin : g_chain
      assign ci = g_bit[i-1].co;
    end else begin : g_local
      assign ci = cin[i];
    end

    full_adder u_fa (
      .a     (a[i]),
      .b     (b[i]),
      .cin   (ci),
      .sum   (cell_sum[i]),
      .carry (co)
    );

    assign cell_carry[i] = co;
  end

  logic [WIDTH-1:0] sum_d,   sum_q;
  logic [WIDTH-1:0] carry_d, carry_q;
  logic             valid_d, valid_q;

  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = 1'b0;
    if (!rst_n) begin
      sum_d   = '0;
      carry_d = '0;
    end else if (in_valid) begin
      sum_d   = cell_sum;
      carry_d = cell_carry;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    sum_q   <= sum_d;
    carry_q <= carry_d;
    valid_q <= valid_d;
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_fa_array_reg.sv
// Scoreboard bench for fa_array_reg: 1-bit carry-save, 8-bit carry-save and 8-bit ripple
// instances share one stimulus stream; a negedge monitor checks them against an arithmetic model.
module tb_fa_array_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a, b, cin;

  logic       sum1, carry1, ov1;
  logic [7:0] sum_cs, carry_cs, sum_rp, carry_rp;
  logic       ov_cs, ov_rp;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fa_array_reg #(.WIDTH(1), .RIPPLE(0)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a[0]),
    .b         (b[0]),
    .cin       (cin[0]),
    .sum       (sum1),
    .carry     (carry1),
    .out_valid (ov1)
  );

  fa_array_reg #(.WIDTH(8), .RIPPLE(0)) u_dut_cs (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum_cs),
    .carry     (carry_cs),
    .out_valid (ov_cs)
  );

  fa_array_reg #(.WIDTH(8), .RIPPLE(1)) u_dut_rp (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum_rp),
    .carry     (carry_rp),
    .out_valid (ov_rp)
  );

  typedef struct packed {
    logic       s1;
    logic       c1;
    logic [7:0] scs;
    logic [7:0] ccs;
    logic [7:0] srp;
    logic [7:0] crp;
  } exp_t;

  exp_t exp_q[$];

  // Reference: column sums for carry-save, truncated integer addition for ripple.
  function automatic exp_t model(input logic [7:0] fa, input logic [7:0] fb,
                                 input logic [7:0] fc);
    exp_t        e;
    int unsigned t;
    int unsigned mask;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      t = int'(fa[i]) + int'(fb[i]) + int'(fc[i]);
      e.scs[i] = (t % 2) == 1;
      e.ccs[i] = (t / 2) == 1;
    end
    t = int'(fa) + int'(fb) + int'(fc[0]);
    e.srp = t[7:0];
    for (int i = 0; i < 8; i++) begin
      mask = (32'd1 << (i + 1)) - 1;
      t = (int'(fa) & mask) + (int'(fb) & mask) + int'(fc[0]);
      e.crp[i] = ((t >> (i + 1)) & 1) == 1;
    end
    t = int'(fa[0]) + int'(fb[0]) + int'(fc[0]);
    e.s1 = (t % 2) == 1;
    e.c1 = (t / 2) == 1;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
    end
  endtask

  // Drive one cycle; inputs change 1 time unit after the rising edge.
  task automatic drive(input logic r, input logic v, input logic [7:0] da,
                       input logic [7:0] db, input logic [7:0] dc);
    rst_n    = r;
    in_valid = v;
    a        = da;
    b        = db;
    cin      = dc;
    if (r && v) exp_q.push_back(model(da, db, dc));
    @(posedge clk);
    #1;
  endtask

  // Monitor: inputs seen at each edge, outputs checked on the falling edge.
  logic rst_seen = 1'b0;
  logic inv_seen = 1'b0;
  exp_t hold_e   = '0;

  always @(posedge clk) begin
    rst_seen = rst_n;
    inv_seen = in_valid;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_seen) begin
      chk("rst_valid", {5'b0, ov1, ov_cs, ov_rp}, 8'h00);
      chk("rst_w1", {6'b0, sum1, carry1}, 8'h00);
      chk("rst_cs", sum_cs | carry_cs, 8'h00);
      chk("rst_rp", sum_rp | carry_rp, 8'h00);
      hold_e = '0;
    end else begin
      chk("out_valid", {5'b0, ov1, ov_cs, ov_rp}, inv_seen ? 8'h07 : 8'h00);
      if (ov_rp) begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", 8'h01, 8'h00);
        end else begin
          e = exp_q.pop_front();
          hold_e = e;
        end
      end
      chk("w1_sum", {7'b0, sum1}, {7'b0, hold_e.s1});
      chk("w1_carry", {7'b0, carry1}, {7'b0, hold_e.c1});
      chk("cs_sum", sum_cs, hold_e.scs);
      chk("cs_carry", carry_cs, hold_e.ccs);
      chk("rp_sum", sum_rp, hold_e.srp);
      chk("rp_carry", carry_rp, hold_e.crp);
    end
  end

  logic [7:0] ra, rb, rc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = '0;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

    // Single-bit truth table sweep, (a,b,cin) with a as the MSB.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, {7'b0, k[2]}, {7'b0, k[1]}, {7'b0, k[0]});
      chk("tt_pair", {6'b0, sum1, carry1},
          (k == 0) ? 8'h0 : (k == 7) ? 8'h3 : (k == 1 || k == 2 || k == 4) ? 8'h2 : 8'h1);
      chk("tt_valid", {7'b0, ov1}, 8'h01);
    end

    // Reset wins over a valid input, then the first valid result follows release.
    drive(1'b0, 1'b1, 8'h01, 8'h01, 8'h01);
    chk("rst_pair", {6'b0, sum1, carry1, ov1}, 8'h00);
    drive(1'b1, 1'b1, 8'h01, 8'h01, 8'h01);
    chk("rel_pair", {5'b0, sum1, carry1, ov1}, 8'h07);

    // Hold on in_valid=0 with changed inputs.
    drive(1'b1, 1'b1, 8'h01, 8'h01, 8'h00);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("hold_pair", {5'b0, sum1, carry1, ov1}, 8'h02);

    drive(1'b1, 1'b1, 8'hF0, 8'hCC, 8'hAA);
    chk("cs_vec_sum", sum_cs, 8'h96);
    chk("cs_vec_carry", carry_cs, 8'hE8);

    drive(1'b1, 1'b1, 8'hFF, 8'h01, 8'hFE);
    chk("rp_vec1_sum", sum_rp, 8'h00);
    chk("rp_vec1_cout", {7'b0, carry_rp[7]}, 8'h01);
    drive(1'b1, 1'b1, 8'h3C, 8'h0F, 8'hFF);
    chk("rp_vec2_sum", sum_rp, 8'h4C);
    chk("rp_vec2_cout", {7'b0, carry_rp[7]}, 8'h00);

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 8'($urandom);
      drive(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)), ra, rb, rc);
    end
    drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);

    @(negedge clk);
    #1;
    chk("sb_drain", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
